// File: rtl/io_arbiter.sv
// Round-robin sequencer that drives the select bus of the tri-state io_block.
// It grants one lane at a time, and every release passes through one all-isolated turnaround cycle.
module io_arbiter #(
    parameter int wire_width = 3,
    parameter int max_hold   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [wire_width-1:0]   req,
    input  logic [wire_width-1:0]   dir,
    output logic [2*wire_width-1:0] select,
    output logic [wire_width-1:0]   grant,
    output logic                    busy
);

    localparam int IDX_W = (wire_width > 1) ? $clog2(wire_width) : 1;
    localparam int CNT_W = (max_hold > 1) ? $clog2(max_hold) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(max_hold - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        g_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2*wire_width-1:0] select_q;
    logic [wire_width-1:0]   grant_q;
    logic                    busy_q;

    logic [IDX_W-1:0]        win_d;
    logic                    win_vld_d;

    // Select field for one lane: 01 = lane drives port, 10 = port drives lane.
    function automatic logic [2*wire_width-1:0] sel_code(input logic [IDX_W-1:0] idx,
                                                         input logic             d);
        logic [2*wire_width-1:0] s;
        s = '0;
        for (int i = 0; i < wire_width; i++) begin
            if (idx == IDX_W'(i)) begin
                s[2*i +: 2] = d ? 2'b01 : 2'b10;
            end
        end
        return s;
    endfunction

    function automatic logic [wire_width-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [wire_width-1:0] o;
        o = '0;
        for (int i = 0; i < wire_width; i++) begin
            if (idx == IDX_W'(i)) begin
                o[i] = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] n;
        if (idx == IDX_W'(wire_width - 1)) begin
            n = '0;
        end else begin
            n = idx + 1'b1;
        end
        return n;
    endfunction

    // Search downwards so the lane closest to rr_ptr overwrites any later candidate.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        win_d     = '0;
        win_vld_d = 1'b0;
        pos       = 0;
        pos_idx   = '0;
        for (int i = wire_width - 1; i >= 0; i--) begin
            pos     = (int'(rr_ptr_q) + i) % wire_width;
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                win_d     = pos_idx;
                win_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            g_q      <= '0;
            cnt_q    <= '0;
            select_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (win_vld_d) begin
                        state_q  <= GRANT;
                        g_q      <= win_d;
                        cnt_q    <= '0;
                        select_q <= sel_code(win_d, dir[win_d]);
                        grant_q  <= onehot(win_d);
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        select_q <= '0;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                    end
                end
                GRANT: begin
                    // Release drops every field to 00 for one cycle before the next grant.
                    if (!req[g_q] || (cnt_q == CNT_LAST)) begin
                        state_q  <= TURN;
                        rr_ptr_q <= next_ptr(g_q);
                        select_q <= '0;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    select_q <= '0;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign select = select_q;
    assign grant  = grant_q;
    assign busy   = busy_q;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_busy_grant    : assert property (@(posedge clk) disable iff (rst) busy_q == (|grant_q));

endmodule

// File: tb/tb_io_arbiter.sv
// Directed and randomized checks of io_arbiter with wire_width = 3, max_hold = 4.
module tb_io_arbiter;

    localparam int W  = 3;
    localparam int MH = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] req;
    logic [W-1:0] dir;
    logic [5:0]   select;
    logic [W-1:0] grant;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    io_arbiter #(.wire_width(W), .max_hold(MH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .dir    (dir),
        .select (select),
        .grant  (grant),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        dir = '0;
        step();
        rst = 1'b0;
    endtask

    // Reference model state: 0 idle, 1 grant, 2 turn
    int         m_state, m_g, m_cnt, m_ptr;
    logic       m_d;
    logic [5:0] prev_sel;
    int         run_len;

    task automatic model_next();
        int w;
        bit found;
        if (rst) begin
            m_state = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_d = 1'b0;
        end else if (m_state == 1) begin
            if (!req[m_g] || m_cnt == MH - 1) begin
                m_state = 2;
                m_ptr   = (m_g + 1) % W;
            end else begin
                m_cnt++;
            end
        end else begin
            found = 0;
            w     = 0;
            for (int k = 0; k < W; k++) begin
                if (!found && req[(m_ptr + k) % W]) begin
                    found = 1;
                    w     = (m_ptr + k) % W;
                end
            end
            if (found) begin
                m_state = 1; m_g = w; m_d = dir[w]; m_cnt = 0;
            end else begin
                m_state = 0;
            end
        end
    endtask

    function automatic logic [5:0] model_sel();
        logic [5:0] s;
        s = '0;
        if (m_state == 1) s[2*m_g +: 2] = m_d ? 2'b01 : 2'b10;
        return s;
    endfunction

    initial begin
        logic [5:0]   exp_sel;
        logic [W-1:0] exp_gnt;
        logic [W-1:0] gnt_from_sel;
        int           nz_fields;
        int           lane;

        rst = 1'b1;
        req = '0;
        dir = '0;
        step();

        // Reset mid-grant
        do_reset();
        chk("rst_select", 32'(select), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req = 3'b010; dir = 3'b010;
        step();
        chk("l1_drive_select", 32'(select), 32'b000100);
        chk("l1_drive_grant", 32'(grant), 32'b010);
        rst = 1'b1;
        step();
        chk("midgrant_rst_select", 32'(select), 32'h0);
        chk("midgrant_rst_grant", 32'(grant), 32'h0);
        chk("midgrant_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0; req = 3'b011; dir = 3'b000;
        step();
        chk("post_rst_grant", 32'(grant), 32'b001);
        chk("post_rst_select", 32'(select), 32'b000010);

        // Single request latency and release
        do_reset();
        req = 3'b100; dir = 3'b000;
        for (int e = 0; e < 3; e++) begin
            step();
            chk("l2_hold_select", 32'(select), 32'b100000);
            chk("l2_hold_busy", 32'(busy), 32'h1);
        end
        req = 3'b000;
        step();
        chk("l2_release_select", 32'(select), 32'h0);
        chk("l2_release_busy", 32'(busy), 32'h0);
        step();
        chk("l2_idle_select", 32'(select), 32'h0);
        chk("l2_idle_grant", 32'(grant), 32'h0);

        // Hold limit with a sole continuous requester
        do_reset();
        req = 3'b001; dir = 3'b001;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < MH; c++) begin
                step();
                chk("hold_select", 32'(select), 32'b000001);
            end
            step();
            chk("hold_turn", 32'(select), 32'h0);
        end

        // Round-robin fairness with all lanes requesting
        do_reset();
        req = 3'b111; dir = 3'b000;
        for (int k = 0; k < 4; k++) begin
            lane = k % W;
            for (int c = 0; c < MH; c++) begin
                step();
                chk("rr_grant", 32'(grant), 32'(1) << lane);
                chk("rr_select", 32'(select), 32'(2) << (2 * lane));
            end
            step();
            chk("rr_turn", 32'(select), 32'h0);
        end

        // Direction latched at grant
        do_reset();
        req = 3'b010; dir = 3'b000;
        step();
        chk("dir_latch_first", 32'(select), 32'b001000);
        dir = 3'b010;
        for (int c = 1; c < MH; c++) begin
            step();
            chk("dir_latch_hold", 32'(select), 32'b001000);
        end
        step();
        chk("dir_latch_release", 32'(select), 32'h0);

        // Random contention run against the reference model
        prev_sel = '0;
        run_len  = 0;
        for (int i = 0; i < 10000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 63) == 0);
            req = W'($urandom);
            dir = W'($urandom);
            model_next();
            step();
            exp_sel = model_sel();
            chk("rand_select", 32'(select), 32'(exp_sel));
            nz_fields    = 0;
            gnt_from_sel = '0;
            for (int l = 0; l < W; l++) begin
                if (select[2*l +: 2] != 2'b00) begin
                    nz_fields++;
                    gnt_from_sel[l] = 1'b1;
                end
                chk("rand_no_code11", 32'(select[2*l +: 2] == 2'b11), 32'h0);
            end
            chk("rand_one_field", 32'(nz_fields > 1), 32'h0);
            chk("rand_grant_sel", 32'(grant), 32'(gnt_from_sel));
            chk("rand_busy", 32'(busy), 32'(|gnt_from_sel));
            if (prev_sel != 0 && select != 0) begin
                chk("rand_back_to_back", 32'(select), 32'(prev_sel));
                run_len++;
            end else begin
                run_len = (select != 0) ? 1 : 0;
            end
            chk("rand_hold_max", 32'(run_len > MH), 32'h0);
            exp_gnt  = '0;
            prev_sel = select;
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
